instruction_fetch: RTL and testbench

Fetch stage that sits directly upstream of the instruction memory: owns the program counter and drives the 6-bit ROM address. Captures the returned 32-bit word into an instruction register. Presents that word to decode with a valid/ready handshake. Supports taken-branch redirect with flush, back-pressure stall, PC wrap-around and a halt state.

---
 rtl/instruction_fetch_if.sv | 40 ++++
 rtl/instruction_fetch.sv | 105 ++++++++++
 tb/tb_instruction_fetch.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Bundle between the fetch stage, instruction memory and decode.
// The fetch stage takes the master side.
interface instruction_fetch_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              ir_ready;
  logic              ir_valid;
  logic [DATA_W-1:0] ir_data;
  logic [ADDR_W-1:0] ir_pc;
  logic              halted;

  modport master (
    output imem_addr,
    input  imem_data,
    input  branch_taken,
    input  branch_target,
    input  ir_ready,
    output ir_valid,
    output ir_data,
    output ir_pc,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output branch_taken,
    output branch_target,
    output ir_ready,
    input  ir_valid,
    input  ir_data,
    input  ir_pc,
    input  halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the ROM address and holds the fetched word
// in an instruction register offered to decode with valid/ready.
module instruction_fetch #(
  parameter int                  ADDR_W    = 6,
  parameter int                  DATA_W    = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
  parameter logic [DATA_W-1:0]   HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instruction_fetch_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALTED
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_ir_valid;
  logic [DATA_W-1:0] r_ir_data;
  logic [ADDR_W-1:0] r_ir_pc;
  logic              r_halted;

  state_t            w_state;
  logic [ADDR_W-1:0] w_pc;
  logic              w_ir_valid;
  logic [DATA_W-1:0] w_ir_data;
  logic [ADDR_W-1:0] w_ir_pc;
  logic              w_halted;
  logic              w_advance;

  assign w_advance = !r_ir_valid || bus.ir_ready;

  always_comb begin
    w_state    = r_state;
    w_pc       = r_pc;
    w_ir_valid = r_ir_valid;
    w_ir_data  = r_ir_data;
    w_ir_pc    = r_ir_pc;
    w_halted   = r_halted;
    case (r_state)
      S_IDLE: begin
        w_state = S_FETCH;
        if (bus.branch_taken) w_pc = bus.branch_target;
      end
      S_FETCH: begin
        // Branch outranks both halt detection and the handshake.
        if (bus.branch_taken) begin
          w_pc       = bus.branch_target;
          w_ir_valid = 1'b0;
        end else if (w_advance) begin
          if (bus.imem_data == HALT_WORD) begin
            w_ir_valid = 1'b0;
            w_halted   = 1'b1;
            w_state    = S_HALTED;
          end else begin
            w_ir_data  = bus.imem_data;
            w_ir_pc    = r_pc;
            w_ir_valid = 1'b1;
            w_pc       = r_pc + ADDR_W'(1);
          end
        end
      end
      S_HALTED: begin
        w_ir_valid = 1'b0;
        if (bus.branch_taken) begin
          w_pc     = bus.branch_target;
          w_halted = 1'b0;
          w_state  = S_FETCH;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_ir_valid <= 1'b0;
      r_ir_data  <= '0;
      r_ir_pc    <= '0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_pc       <= w_pc;
      r_ir_valid <= w_ir_valid;
      r_ir_data  <= w_ir_data;
      r_ir_pc    <= w_ir_pc;
      r_halted   <= w_halted;
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.ir_valid  = r_ir_valid;
  assign bus.ir_data   = r_ir_data;
  assign bus.ir_pc     = r_ir_pc;
  assign bus.halted    = r_halted;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: ROM returns its own address, with an
// optional halt word planted at address 7.
module tb_instruction_fetch;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] HALT = 32'hFFFF_FFFF;

  logic clk;
  logic rst_n;
  logic halt_en;
  int   errors;
  int   checks;

  instruction_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  instruction_fetch #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .RESET_PC (6'd0),
    .HALT_WORD(HALT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (halt_en && bus.imem_addr == 6'd7) bus.imem_data = HALT;
    else                                  bus.imem_data = {26'd0, bus.imem_addr};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ir(input string tag, input int d, input int p, input int a);
    chk({tag, ".valid"}, {31'd0, bus.ir_valid}, 32'd1);
    chk({tag, ".data"},  bus.ir_data, 32'(d));
    chk({tag, ".pc"},    {26'd0, bus.ir_pc}, 32'(p));
    chk({tag, ".addr"},  {26'd0, bus.imem_addr}, 32'(a));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    halt_en = 1'b0;
    rst_n = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.ir_ready      = 1'b1;

    #12;
    chk("rst.valid",  {31'd0, bus.ir_valid}, 32'd0);
    chk("rst.addr",   {26'd0, bus.imem_addr}, 32'd0);
    chk("rst.halted", {31'd0, bus.halted}, 32'd0);
    chk("rst.data",   bus.ir_data, 32'd0);
    chk("rst.pc",     {26'd0, bus.ir_pc}, 32'd0);
    rst_n = 1'b1;

    // IDLE cycle
    tick();
    chk("idle.valid", {31'd0, bus.ir_valid}, 32'd0);
    chk("idle.addr",  {26'd0, bus.imem_addr}, 32'd0);

    for (int k = 0; k <= 4; k++) begin
      tick();
      chk_ir($sformatf("seq%0d", k), k, k, k + 1);
    end

    // stall holding word 4
    bus.ir_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_ir($sformatf("stall%0d", k), 4, 4, 5);
    end
    bus.ir_ready = 1'b1;
    for (int k = 5; k <= 10; k++) begin
      tick();
      chk_ir($sformatf("resume%0d", k), k, k, k + 1);
    end

    // branch flush while stalled
    bus.ir_ready      = 1'b0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 6'd60;
    tick();
    bus.branch_taken = 1'b0;
    bus.ir_ready     = 1'b1;
    chk("flush.valid", {31'd0, bus.ir_valid}, 32'd0);
    chk("flush.addr",  {26'd0, bus.imem_addr}, 32'd60);
    for (int k = 60; k <= 63; k++) begin
      tick();
      chk_ir($sformatf("br%0d", k), k, k, (k + 1) % 64);
    end
    tick();
    chk_ir("wrap0", 0, 0, 1);
    tick();
    chk_ir("wrap1", 1, 1, 2);

    // halt word at address 7
    halt_en = 1'b1;
    for (int k = 2; k <= 6; k++) begin
      tick();
      chk_ir($sformatf("pre_halt%0d", k), k, k, k + 1);
    end
    tick();
    chk("halt.valid",  {31'd0, bus.ir_valid}, 32'd0);
    chk("halt.halted", {31'd0, bus.halted}, 32'd1);
    chk("halt.addr",   {26'd0, bus.imem_addr}, 32'd7);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("halted%0d.valid", k),  {31'd0, bus.ir_valid}, 32'd0);
      chk($sformatf("halted%0d.halted", k), {31'd0, bus.halted}, 32'd1);
      chk($sformatf("halted%0d.addr", k),   {26'd0, bus.imem_addr}, 32'd7);
    end
    bus.branch_taken  = 1'b1;
    bus.branch_target = 6'd2;
    tick();
    bus.branch_taken = 1'b0;
    chk("unhalt.halted", {31'd0, bus.halted}, 32'd0);
    chk("unhalt.valid",  {31'd0, bus.ir_valid}, 32'd0);
    chk("unhalt.addr",   {26'd0, bus.imem_addr}, 32'd2);
    tick();
    chk_ir("unhalt.word", 2, 2, 3);

    // branch coinciding with halt word: branch wins
    for (int k = 3; k <= 6; k++) begin
      tick();
      chk_ir($sformatf("again%0d", k), k, k, k + 1);
    end
    bus.branch_taken  = 1'b1;
    bus.branch_target = 6'd18;
    tick();
    bus.branch_taken = 1'b0;
    chk("race.halted", {31'd0, bus.halted}, 32'd0);
    chk("race.valid",  {31'd0, bus.ir_valid}, 32'd0);
    chk("race.addr",   {26'd0, bus.imem_addr}, 32'd18);
    tick();
    chk_ir("race18", 18, 18, 19);
    tick();
    chk_ir("race19", 19, 19, 20);

    // async reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.valid",  {31'd0, bus.ir_valid}, 32'd0);
    chk("arst.addr",   {26'd0, bus.imem_addr}, 32'd0);
    chk("arst.halted", {31'd0, bus.halted}, 32'd0);
    chk("arst.data",   bus.ir_data, 32'd0);
    tick();
    chk("arst_hold.addr", {26'd0, bus.imem_addr}, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("re_idle.valid", {31'd0, bus.ir_valid}, 32'd0);
    tick();
    chk_ir("re0", 0, 0, 1);
    tick();
    chk_ir("re1", 1, 1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
